// File: rtl/lc3_mem_ctrl_param_if.sv
// Bus bundle between the LC-3 datapath/control and the parametrised memory
// controller: load strobes, request handshake, bus data in and the
// MDR/device/status values coming back.
interface lc3_mem_ctrl_param_if #(
  parameter int DATA_W = 16
);
  logic              i_LD_MAR;
  logic              i_LD_MDR;
  logic              i_RW;
  logic              i_MIO_EN;
  logic [DATA_W-1:0] i_Bus;
  logic [DATA_W-1:0] o_Bus;
  logic              o_Ready_Bit;
  logic [DATA_W-1:0] o_Dev_Reg;
  logic              o_Fault;

  modport master (
    output i_LD_MAR, i_LD_MDR, i_RW, i_MIO_EN, i_Bus,
    input  o_Bus, o_Ready_Bit, o_Dev_Reg, o_Fault
  );

  modport slave (
    input  i_LD_MAR, i_LD_MDR, i_RW, i_MIO_EN, i_Bus,
    output o_Bus, o_Ready_Bit, o_Dev_Reg, o_Fault
  );
endinterface

// File: rtl/lc3_mem_ctrl_param.sv
// LC-3 MAR/MDR/RAM wrapper with configurable widths, RAM depth and wait
// states. A request is latched in IDLE, counted down in BUSY, performed on the
// BUSY->DONE edge and acknowledged by a registered ready while in DONE. One
// address outside the RAM selects a device register; every other address
// outside the RAM completes with a one-cycle fault pulse.
module lc3_mem_ctrl_param #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                MEM_AW      = 7,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] DEV_ADDR    = 16'hFE12
) (
  input logic                  i_CLK,
  input logic                  i_RST,
  lc3_mem_ctrl_param_if.slave  bus
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  // One past the last RAM address, one bit wider than MAR so that a RAM as
  // large as the whole address space still has a representable limit.
  localparam logic [ADDR_W:0] RAM_LIMIT = (ADDR_W + 1)'(1) << MEM_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [ADDR_W-1:0]   reqAddr_q, reqAddr_d;
  logic [DATA_W-1:0]   reqData_q, reqData_d;
  logic                reqRw_q, reqRw_d;
  logic [DATA_W-1:0]   rdData_q, rdData_d;
  logic [DATA_W-1:0]   devReg_q, devReg_d;
  logic                ready_q, ready_d;
  logic                fault_q, fault_d;

  logic [DATA_W-1:0]   mem [2**MEM_AW];
  logic [MEM_AW-1:0]   memIdx;
  logic                memWe;
  logic                isRam;
  logic                isDev;

  // Decode of the latched request address; MAR is zero-extended for compares.
  assign memIdx = reqAddr_q[MEM_AW-1:0];
  assign isRam  = ({1'b0, reqAddr_q} < RAM_LIMIT);
  assign isDev  = (reqAddr_q == DEV_ADDR);

  assign bus.o_Bus       = mdr_q;
  assign bus.o_Ready_Bit = ready_q;
  assign bus.o_Dev_Reg   = devReg_q;
  assign bus.o_Fault     = fault_q;

  // MAR follows its load strobe in any state; MDR takes the bus, or the read
  // data once a read request has been acknowledged, and otherwise holds.
  always_comb begin
    mar_d = mar_q;
    mdr_d = mdr_q;
    if (bus.i_LD_MAR) begin
      mar_d = bus.i_Bus[ADDR_W-1:0];
    end
    if (bus.i_LD_MDR) begin
      if (!bus.i_MIO_EN) begin
        mdr_d = bus.i_Bus;
      end else if (ready_q && !reqRw_q) begin
        mdr_d = rdData_q;
      end
    end
  end

  // Request FSM: latch in IDLE, wait out the counter in BUSY, perform the
  // access on the way into DONE and hold DONE until the request is dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reqAddr_d = reqAddr_q;
    reqData_d = reqData_q;
    reqRw_d   = reqRw_q;
    rdData_d  = rdData_q;
    devReg_d  = devReg_q;
    fault_d   = 1'b0;
    memWe     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_MIO_EN) begin
          reqAddr_d = mar_q;
          reqData_d = mdr_q;
          reqRw_d   = bus.i_RW;
          cnt_d     = CNT_W'(WAIT_CYCLES);
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (isRam) begin
            if (reqRw_q) begin
              memWe = 1'b1;
            end else begin
              rdData_d = mem[memIdx];
            end
          end else if (isDev) begin
            if (reqRw_q) begin
              devReg_d = reqData_q;
            end else begin
              rdData_d = devReg_q;
            end
          end else begin
            fault_d = 1'b1;
            if (!reqRw_q) begin
              rdData_d = '0;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (!bus.i_MIO_EN) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == DONE);
  end

  // Register update; reset aborts any request in flight before it commits.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      reqAddr_q <= '0;
      reqData_q <= '0;
      reqRw_q   <= 1'b0;
      rdData_q  <= '0;
      devReg_q  <= '0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      reqAddr_q <= reqAddr_d;
      reqData_q <= reqData_d;
      reqRw_q   <= reqRw_d;
      rdData_q  <= rdData_d;
      devReg_q  <= devReg_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  // RAM array has no reset so its contents survive a controller reset.
  always_ff @(posedge i_CLK) begin
    if (memWe) begin
      mem[memIdx] <= reqData_q;
    end
  end

endmodule

// File: tb/tb_lc3_mem_ctrl_param.sv
// Directed bench for lc3_mem_ctrl_param: a 16-bit instance with two wait
// states and a 32-bit instance with no wait states and a 16-word RAM, both
// exercised from transaction tables plus hand-built reset/hold sequences.
module tb_lc3_mem_ctrl_param;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          rw;
    logic [31:0] expRd;
    bit          expFault;
    logic [31:0] expDev;
    string       name;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vec_t tab16[$];
  vec_t tab32[$];

  lc3_mem_ctrl_param_if #(.DATA_W(16)) bus16 ();
  lc3_mem_ctrl_param_if #(.DATA_W(32)) bus32 ();

  lc3_mem_ctrl_param #(
    .DATA_W(16), .ADDR_W(16), .MEM_AW(7), .WAIT_CYCLES(2), .DEV_ADDR(16'hFE12)
  ) dut16 (
    .i_CLK(clk),
    .i_RST(rst),
    .bus  (bus16)
  );

  lc3_mem_ctrl_param #(
    .DATA_W(32), .ADDR_W(16), .MEM_AW(4), .WAIT_CYCLES(0), .DEV_ADDR(16'hFE12)
  ) dut32 (
    .i_CLK(clk),
    .i_RST(rst),
    .bus  (bus32)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence loses track of the handshake.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic setIn(input bit wide, input bit ldMar, input bit ldMdr,
                       input bit rw, input bit mio, input logic [31:0] data);
    if (wide) begin
      bus32.i_LD_MAR = ldMar;
      bus32.i_LD_MDR = ldMdr;
      bus32.i_RW     = rw;
      bus32.i_MIO_EN = mio;
      bus32.i_Bus    = data;
    end else begin
      bus16.i_LD_MAR = ldMar;
      bus16.i_LD_MDR = ldMdr;
      bus16.i_RW     = rw;
      bus16.i_MIO_EN = mio;
      bus16.i_Bus    = data[15:0];
    end
  endtask

  function automatic logic [31:0] getBus(input bit wide);
    return wide ? bus32.o_Bus : {16'h0, bus16.o_Bus};
  endfunction

  function automatic logic [31:0] getDev(input bit wide);
    return wide ? bus32.o_Dev_Reg : {16'h0, bus16.o_Dev_Reg};
  endfunction

  function automatic logic [31:0] getReady(input bit wide);
    return {31'h0, wide ? bus32.o_Ready_Bit : bus16.o_Ready_Bit};
  endfunction

  function automatic logic [31:0] getFault(input bit wide);
    return {31'h0, wide ? bus32.o_Fault : bus16.o_Fault};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One complete transaction: load MAR (and MDR for writes), raise the
  // request, measure edges to ready, check fault/device/read data, release.
  task automatic applyStimulus(input vec_t v, input bit wide);
    int latency;
    bit seen;
    setIn(wide, 1'b1, 1'b0, 1'b0, 1'b0, v.addr);
    @(posedge clk); #1;
    if (v.rw) begin
      setIn(wide, 1'b0, 1'b1, 1'b0, 1'b0, v.data);
      @(posedge clk); #1;
    end
    setIn(wide, 1'b0, !v.rw, v.rw, 1'b1, v.data);
    latency = 0;
    seen    = 1'b0;
    while (!seen && latency < 20) begin
      @(posedge clk);
      latency++;
      @(negedge clk);
      if (getReady(wide) == 32'd1) seen = 1'b1;
    end
    checkOutput({v.name, " latency"}, 32'(latency), wide ? 32'd2 : 32'd4);
    checkOutput({v.name, " fault"}, getFault(wide), {31'h0, v.expFault});
    checkOutput({v.name, " dev"}, getDev(wide), v.expDev);
    @(posedge clk);
    @(negedge clk);
    checkOutput({v.name, " fault drop"}, getFault(wide), 32'd0);
    checkOutput({v.name, " ready hold"}, getReady(wide), 32'd1);
    if (!v.rw) begin
      checkOutput({v.name, " rdata"}, getBus(wide), v.expRd);
    end
    setIn(wide, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({v.name, " ready drop"}, getReady(wide), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    setIn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    setIn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    //                  addr          data          rw    expRd         flt   expDev
    tab16.push_back('{32'h0000,     32'h0ABC,     1'b1, 32'h0,        1'b0, 32'h0000, "w16 0"});
    tab16.push_back('{32'h0007,     32'hA5A5,     1'b1, 32'h0,        1'b0, 32'h0000, "w16 7"});
    tab16.push_back('{32'h0007,     32'h0,        1'b0, 32'hA5A5,     1'b0, 32'h0000, "r16 7"});
    tab16.push_back('{32'hFE12,     32'h00FF,     1'b1, 32'h0,        1'b0, 32'h00FF, "w16 dev"});
    tab16.push_back('{32'hFE12,     32'h0,        1'b0, 32'h00FF,     1'b0, 32'h00FF, "r16 dev"});
    tab16.push_back('{32'h4000,     32'h0,        1'b0, 32'h0000,     1'b1, 32'h00FF, "r16 oor"});
    tab16.push_back('{32'h4000,     32'h1111,     1'b1, 32'h0,        1'b1, 32'h00FF, "w16 oor"});
    tab16.push_back('{32'h0000,     32'h0,        1'b0, 32'h0ABC,     1'b0, 32'h00FF, "r16 0"});
    tab16.push_back('{32'hFE12,     32'h0,        1'b0, 32'h00FF,     1'b0, 32'h00FF, "r16 dev2"});
    tab16.push_back('{32'h007F,     32'h7F7F,     1'b1, 32'h0,        1'b0, 32'h00FF, "w16 127"});
    tab16.push_back('{32'h007F,     32'h0,        1'b0, 32'h7F7F,     1'b0, 32'h00FF, "r16 127"});
    tab16.push_back('{32'h0080,     32'h0,        1'b0, 32'h0000,     1'b1, 32'h00FF, "r16 128"});

    tab32.push_back('{32'h000F,     32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 32'h0,        "w32 15"});
    tab32.push_back('{32'h000F,     32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        "r32 15"});
    tab32.push_back('{32'h0010,     32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        "r32 16"});
    tab32.push_back('{32'h0010,     32'h11111111, 1'b1, 32'h0,        1'b1, 32'h0,        "w32 16"});
    tab32.push_back('{32'h000F,     32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        "r32 15b"});
    tab32.push_back('{32'hFE12,     32'hCAFEF00D, 1'b1, 32'h0,        1'b0, 32'hCAFEF00D, "w32 dev"});
    tab32.push_back('{32'hFE12,     32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, "r32 dev"});

    #12;
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      checkOutput("reset ready", getReady(w[0]), 32'd0);
      checkOutput("reset fault", getFault(w[0]), 32'd0);
      checkOutput("reset mdr", getBus(w[0]), 32'd0);
      checkOutput("reset dev", getDev(w[0]), 32'd0);
    end
    @(posedge clk); #1;

    // Reset in the first BUSY cycle of a write must drop the write.
    applyStimulus('{32'h0005, 32'h1234, 1'b1, 32'h0, 1'b0, 32'h0, "w16 5 pre"}, 1'b0);
    setIn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0005);
    @(posedge clk); #1;
    setIn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hBEEF);
    @(posedge clk); #1;
    checkOutput("rst mdr loaded", getBus(1'b0), 32'hBEEF);
    setIn(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hBEEF);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst busy ready", getReady(1'b0), 32'd0);
    checkOutput("rst busy mdr", getBus(1'b0), 32'd0);
    setIn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus('{32'h0005, 32'h0, 1'b0, 32'h1234, 1'b0, 32'h0, "r16 5 post"}, 1'b0);

    foreach (tab16[i]) applyStimulus(tab16[i], 1'b0);

    // Held request plus MAR reloads at request start and during BUSY: the
    // access must still use address 7 and happen only once.
    setIn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0007);
    @(posedge clk); #1;
    setIn(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000);
    @(posedge clk); #1;
    setIn(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFE12);
    @(posedge clk); #1;
    setIn(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000);
    @(posedge clk);
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("hold ready %0d", k), getReady(1'b0), 32'd1);
      checkOutput($sformatf("hold fault %0d", k), getFault(1'b0), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    checkOutput("hold rdata", getBus(1'b0), 32'hA5A5);
    setIn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("hold ready drop", getReady(1'b0), 32'd0);
    @(posedge clk); #1;

    foreach (tab32[i]) applyStimulus(tab32[i], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_mem_ctrl_param.md
Name: lc3_mem_ctrl_param

Overview:
Parametrised successor to the LC-3 MAR/MDR/RAM wrapper. It adds configurable data and address widths, RAM depth, and programmable wait states. A registered ready handshake follows a proper IDLE/BUSY/DONE state machine. It also adds one memory-mapped device register and out-of-range fault reporting. It sits between the datapath bus and the control FSM, which loops on o_Ready_Bit during memory states.

Parameters:
DATA_W, 16, width of bus, MDR, RAM words and device register
ADDR_W, 16, width of MAR; must be <= DATA_W; MAR takes i_Bus[ADDR_W-1:0]
MEM_AW, 7, RAM address bits; RAM depth 2^MEM_AW; RAM region is MAR < 2^MEM_AW
WAIT_CYCLES, 2, extra BUSY cycles before an access completes (0 allowed)
DEV_ADDR, 16'hFE12, MAR value that selects the device register (must lie outside the RAM region)

Ports:
i_CLK  in  1  single clock, rising edge
i_RST  in  1  asynchronous, active-high reset
i_LD_MAR  in  1  load MAR from i_Bus
i_LD_MDR  in  1  load MDR (source selected by i_MIO_EN)
i_RW  in  1  1=write, 0=read; sampled at request start
i_MIO_EN  in  1  memory request enable; held high until ready
i_Bus  in  DATA_W  datapath bus
o_Bus  out  DATA_W  MDR contents; the top level gates this onto the bus
o_Ready_Bit  out  1  registered ready; high while FSM is in DONE
o_Dev_Reg  out  DATA_W  memory-mapped device register
o_Fault  out  1  one-cycle pulse on completion of an out-of-range access

Behaviour:
- Reset (async, i_RST=1):
  - FSM=IDLE; MAR, MDR, wait counter, latched request, read-data register, o_Dev_Reg all cleared to 0; o_Ready_Bit=0, o_Fault=0.
  - RAM contents are not cleared.
  - Reset during BUSY aborts the access; a pending write is not committed.
- MAR: loads on posedge when i_LD_MAR=1, independent of FSM state.
- MDR load rules, applied when i_LD_MDR=1:
  - i_MIO_EN=0: MDR <= i_Bus.
  - i_MIO_EN=1 and o_Ready_Bit=1 with the latched request a read: MDR <= read-data register.
  - i_MIO_EN=1 otherwise: MDR holds its value.
- FSM states:
  - IDLE: when i_MIO_EN=1, latch {MAR, MDR, i_RW} into request registers, load counter=WAIT_CYCLES, go to BUSY.
  - BUSY: if counter==0, perform the access and go to DONE; else decrement the counter. MAR/MDR/i_RW changes during BUSY are ignored.
  - DONE: o_Ready_Bit=1. Stay while i_MIO_EN=1. When i_MIO_EN=0, go to IDLE; ready drops after that edge.
  - Dropping i_MIO_EN during BUSY does not abort the access: the FSM still passes through DONE and exits on the next cycle.
- Latency: if i_MIO_EN is first sampled high at edge N, o_Ready_Bit is high after edge N+1+WAIT_CYCLES.
  - WAIT_CYCLES=2: ready after edge N+3.
  - WAIT_CYCLES=0: ready after edge N+1.
- Back-to-back requests need at least one cycle of i_MIO_EN=0 between them (DONE->IDLE).
- Access, performed on the BUSY->DONE edge:
  - RAM region, write: RAM[addr[MEM_AW-1:0]] <= latched MDR.
  - RAM region, read: read-data register <= RAM word.
  - addr==DEV_ADDR, write: o_Dev_Reg <= latched MDR.
  - addr==DEV_ADDR, read: read-data register <= o_Dev_Reg.
  - Any other address: writes dropped, reads return 0, o_Fault=1 for exactly the first DONE cycle.
- Widths: MAR is zero-extended for address compares. RAM index uses the low MEM_AW bits only inside the RAM region.
- Simultaneous i_LD_MAR with a request start: the request latches the old MAR (value before the edge).

Test Plan:
- Reset mid-write: MAR=5, MDR=16'hBEEF, write request, assert i_RST at the first BUSY cycle. Then read addr 5 -> old value (preloaded 16'h1234); ready=0 and MDR=0 immediately on reset.
- Write/read RAM, WAIT_CYCLES=2: write 16'hA5A5 to addr 7; ready rises 3 edges after the request. Read addr 7 with i_LD_MDR high -> MDR=16'hA5A5 on the first ready edge; o_Bus=16'hA5A5.
- Device register: write 16'h00FF to DEV_ADDR 16'hFE12 -> o_Dev_Reg=16'h00FF at DONE. Read back -> MDR=16'h00FF.
- Out-of-range: read addr 16'h4000 -> MDR=0 and o_Fault high exactly 1 cycle. Write 16'h1111 to 16'h4000 -> no RAM or device change and o_Fault pulses.
- Hold/ignore: keep i_MIO_EN high 5 extra cycles in DONE -> ready stays 1 and no second access occurs. Change MAR during BUSY -> access uses the original address.
- Parametrisation: rerun the RAM test with WAIT_CYCLES=0, DATA_W=32, MEM_AW=4. Ready arrives after 1 edge; a 32'hDEADBEEF round-trip at addr 15 succeeds; addr 16 faults.
